// File: rtl/plab4_net_input_queue_credit.sv
//------------------------------------------------------------------------------
// plab4_net_input_queue_credit
//
// Ring-router input queue for one inter-router channel. It buffers incoming
// messages in a circular buffer and reports a saturated count of free entries
// to the upstream router. The upstream router's adaptive route compute uses
// that count as its congestion input.
//
// Parameters:
//   p_msg_nbits      message width in bits
//   p_num_entries    queue depth (2 or more; need not be a power of two)
//   p_num_free_nbits width of the num_free report
//
// Ports:
//   clk       single clock
//   reset     synchronous, active-high reset
//   in_val    upstream message valid
//   in_rdy    queue can accept a message (registered state only)
//   in_msg    upstream message
//   out_val   head message valid
//   out_rdy   switch accepts the head message
//   out_msg   head message
//   num_free  free entries, saturated to 2^p_num_free_nbits - 1
//
// Optional feature:
//   PLAB4_NET_INPUT_QUEUE_BYPASS_EN - when defined, an empty queue forwards
//   in_val/in_msg straight to out_val/out_msg. A message that the switch
//   takes in that same cycle is never written into the buffer.
//------------------------------------------------------------------------------
module plab4_net_input_queue_credit #(
    parameter int p_msg_nbits      = 32,
    parameter int p_num_entries    = 4,
    parameter int p_num_free_nbits = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_msg_nbits-1:0]      in_msg,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [p_msg_nbits-1:0]      out_msg,
    output logic [p_num_free_nbits-1:0] num_free
);

    localparam int c_addr_nbits = $clog2(p_num_entries);
    localparam int c_cnt_nbits  = $clog2(p_num_entries + 1);

    localparam logic [c_addr_nbits-1:0] c_last_addr  = c_addr_nbits'(p_num_entries - 1);
    localparam logic [c_cnt_nbits-1:0]  c_full_count = c_cnt_nbits'(p_num_entries);
    localparam logic [31:0]             c_free_max   = 32'((1 << p_num_free_nbits) - 1);

    logic [p_msg_nbits-1:0]  entries [p_num_entries];
    logic [c_addr_nbits-1:0] head;
    logic [c_addr_nbits-1:0] tail;
    logic [c_cnt_nbits-1:0]  count;

    logic        enq;
    logic        deq;
    logic        bypass_fire;
    logic [31:0] free_raw;
    logic [31:0] free_sat;

    // Handshake decode. in_rdy looks only at the registered count, so a full
    // queue refuses a message even in a cycle where it is draining one.
    // A bypassed message counts as both enqueued and dequeued. Both events
    // are suppressed so the buffer and count do not change.
    always_comb begin
        in_rdy = (count != c_full_count);
`ifdef PLAB4_NET_INPUT_QUEUE_BYPASS_EN
        if (count == '0) begin
            out_val = in_val;
            out_msg = in_msg;
        end else begin
            out_val = 1'b1;
            out_msg = entries[head];
        end
        bypass_fire = (count == '0) && in_val && out_rdy;
`else
        out_val     = (count != '0);
        out_msg     = entries[head];
        bypass_fire = 1'b0;
`endif
        enq = in_val && in_rdy && !bypass_fire;
        deq = out_val && out_rdy && !bypass_fire;
    end

    // Free-entry report, computed at 32 bits from the registered count and
    // then clamped to what the report width can carry.
    always_comb begin
        free_raw = 32'(p_num_entries) - 32'(count);
        free_sat = (free_raw > c_free_max) ? c_free_max : free_raw;
        num_free = p_num_free_nbits'(free_sat);
    end

    // Pointer and occupancy state. Wrap uses an explicit compare so that
    // depths that are not a power of two still work.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= (tail == c_last_addr) ? '0 : tail + c_addr_nbits'(1);
            end
            if (deq) begin
                head <= (head == c_last_addr) ? '0 : head + c_addr_nbits'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + c_cnt_nbits'(1);
                2'b01:   count <= count - c_cnt_nbits'(1);
                default: count <= count;
            endcase
        end
    end

    // Message storage. It is written only on an accepted enqueue, and never
    // during reset, so messages that are refused leave the contents alone.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            entries[tail] <= in_msg;
        end
    end

endmodule

// File: tb/tb_plab4_net_input_queue_credit.sv
//------------------------------------------------------------------------------
// tb_plab4_net_input_queue_credit
//
// Self-checking bench for plab4_net_input_queue_credit at default parameters.
// Each scenario task drives the handshakes and checks in_rdy, out_val and
// num_free against a small occupancy model. Accepted messages are pushed onto
// a scoreboard queue. A negedge monitor pops the queue and checks out_msg
// every time the DUT hands a message to the switch. Honours
// PLAB4_NET_INPUT_QUEUE_BYPASS_EN in the same way as the design.
//------------------------------------------------------------------------------
module tb_plab4_net_input_queue_credit;

`ifdef PLAB4_NET_INPUT_QUEUE_BYPASS_EN
    localparam bit byp = 1'b1;
`else
    localparam bit byp = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;
    logic [1:0]  num_free;

    int          total;
    int          bad;
    int          mcount;
    logic [31:0] sb [$];

    plab4_net_input_queue_credit dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .num_free (num_free)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected report for a given model occupancy: min(4 - count, 3)
    function automatic logic [1:0] exp_nf(input int c);
        int f;
        f = 4 - c;
        if (f > 3) f = 3;
        return 2'(f);
    endfunction

    function automatic logic exp_val(input int c, input logic v);
        return (c != 0) || (byp && v);
    endfunction

    // Scoreboard monitor. It compares each message the switch takes against
    // the oldest accepted message that has not yet been taken.
    always @(negedge clk) begin
        logic [31:0] want;
        if (!reset && out_val && out_rdy) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_output got out_msg=%h, expected no message", out_msg);
            end else begin
                want = sb.pop_front();
                if (out_msg !== want) begin
                    bad++;
                    $display("[TB] FAIL out_msg_order got %h expected %h", out_msg, want);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Apply inputs just after a rising edge and let them settle
    task automatic drive(input logic v, input logic [31:0] m, input logic r);
        in_val  = v;
        in_msg  = m;
        out_rdy = r;
        #1;
    endtask

    // Update the occupancy model for this cycle, push accepted data, then
    // move past the next rising edge
    task automatic commit();
        logic er;
        logic ev;
        logic e;
        logic d;
        er = (mcount != 4);
        ev = exp_val(mcount, in_val);
        e  = in_val && er;
        d  = ev && out_rdy;
        if (e) sb.push_back(in_msg);
        mcount = mcount + (e ? 1 : 0) - (d ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_val = 1'b1;
        in_msg = 32'hDEAD;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        mcount = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            total++;
            if (in_rdy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL reset_in_rdy cycle %0d got %b expected 1", i, in_rdy);
            end
            total++;
            if (out_val !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_out_val cycle %0d got %b expected 0", i, out_val);
            end
            total++;
            if (num_free !== 2'd3) begin
                bad++;
                $display("[TB] FAIL reset_num_free cycle %0d got %0d expected 3", i, num_free);
            end
            commit();
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b0);
            total++;
            if (num_free !== exp_nf(mcount)) begin
                bad++;
                $display("[TB] FAIL fill_num_free step %0d got %0d expected %0d", i, num_free, exp_nf(mcount));
            end
            total++;
            if (in_rdy !== (mcount != 4)) begin
                bad++;
                $display("[TB] FAIL fill_in_rdy step %0d got %b expected %b", i, in_rdy, (mcount != 4));
            end
            commit();
        end
        drive(1'b0, 32'h0, 1'b0);
        total++;
        if (num_free !== 2'd0 || out_val !== 1'b1 || in_rdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fill_full_state got nf=%0d val=%b rdy=%b expected nf=0 val=1 rdy=0",
                     num_free, out_val, in_rdy);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            total++;
            if (out_val !== exp_val(mcount, 1'b0) || num_free !== exp_nf(mcount)) begin
                bad++;
                $display("[TB] FAIL drain_state step %0d got val=%b nf=%0d expected val=%b nf=%0d",
                         i, out_val, num_free, exp_val(mcount, 1'b0), exp_nf(mcount));
            end
            commit();
        end
        drive(1'b0, 32'h0, 1'b0);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain_lost got %0d messages never emitted expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_full_dequeue();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'hB0 + 32'(i), 1'b1);
            total++;
            if (in_rdy !== (mcount != 4) || num_free !== exp_nf(mcount)) begin
                bad++;
                $display("[TB] FAIL full_deq step %0d got rdy=%b nf=%0d expected rdy=%b nf=%0d",
                         i, in_rdy, num_free, (mcount != 4), exp_nf(mcount));
            end
            commit();
        end
        test_drain();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'hC0, 1'b0);
        commit();
        drive(1'b1, 32'hC1, 1'b0);
        commit();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hC2 + 32'(i), 1'b1);
            total++;
            if (num_free !== 2'd2 || in_rdy !== 1'b1 || out_val !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b_hold step %0d got nf=%0d rdy=%b val=%b expected nf=2 rdy=1 val=1",
                         i, num_free, in_rdy, out_val);
            end
            commit();
        end
        test_drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hD0 + 32'(i), 1'b0);
            commit();
        end
        reset = 1'b1;
        drive(1'b1, 32'hD3, 1'b0);
        sb.delete();
        mcount = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            total++;
            if (out_val !== 1'b0 || in_rdy !== 1'b1 || num_free !== 2'd3) begin
                bad++;
                $display("[TB] FAIL reset_mid step %0d got val=%b rdy=%b nf=%0d expected val=0 rdy=1 nf=3",
                         i, out_val, in_rdy, num_free);
            end
            commit();
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h5C, 1'b1);
        total++;
        if (out_val !== exp_val(mcount, 1'b1) || num_free !== 2'd3) begin
            bad++;
            $display("[TB] FAIL bypass_same_cycle got val=%b nf=%0d expected val=%b nf=3",
                     out_val, num_free, exp_val(mcount, 1'b1));
        end
        commit();
        drive(1'b0, 32'h0, 1'b1);
        total++;
        if (out_val !== exp_val(mcount, 1'b0) || num_free !== exp_nf(mcount)) begin
            bad++;
            $display("[TB] FAIL bypass_next_cycle got val=%b nf=%0d expected val=%b nf=%0d",
                     out_val, num_free, exp_val(mcount, 1'b0), exp_nf(mcount));
        end
        commit();
        drive(1'b0, 32'h0, 1'b0);
        total++;
        if (sb.size() != 0 || out_val !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bypass_emitted got pending=%0d val=%b expected pending=0 val=0",
                     sb.size(), out_val);
            sb.delete();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 32'h1000 + 32'(i), 1'($urandom_range(0, 1)));
            total++;
            if (in_rdy !== (mcount != 4) || out_val !== exp_val(mcount, in_val) ||
                num_free !== exp_nf(mcount)) begin
                bad++;
                $display("[TB] FAIL random_state step %0d got rdy=%b val=%b nf=%0d expected rdy=%b val=%b nf=%0d",
                         i, in_rdy, out_val, num_free, (mcount != 4), exp_val(mcount, in_val), exp_nf(mcount));
            end
            commit();
        end
        test_drain();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        mcount  = 0;
        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = 32'h0;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_full_dequeue();
        test_back_to_back();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
